// File: rtl/flag_unit.sv
// Status flag register (SC, P, Z) with a small save/restore stack and
// branch-condition select for the control unit.
module flag_unit #(
  parameter int DEPTH = 4,
  parameter int DW    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic                       stall,
  input  logic                       sc_o,
  input  logic                       sc_en,
  input  logic                       sc_clr,
  input  logic                       pari,
  input  logic                       pari_en,
  input  logic                       pari_clr,
  input  logic [7:0]                 rslt,
  input  logic                       z_en,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       err_clr,
  input  logic [1:0]                 cond,
  output logic                       sc_i,
  output logic                       pari_in,
  output logic                       zero,
  output logic                       take,
  output logic [$clog2(DEPTH):0]     stk_depth,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       stk_ovf,
  output logic                       stk_unf
);
  localparam int AW = $clog2(DEPTH);

  logic          sc_q, sc_d, p_q, p_d, z_q, z_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [AW:0]   depth_q, depth_d;
  logic [DW-1:0] stk_q [DEPTH];
  logic [DW-1:0] cur, alu_f;
  logic [AW-1:0] top_idx, waddr;
  logic          we, full, empty;

  always_comb begin
    cur     = {z_q, p_q, sc_q};
    full    = (depth_q == (AW+1)'(DEPTH));
    empty   = (depth_q == '0);
    top_idx = AW'(depth_q - 1'b1);

    alu_f = cur;
    if (alu_valid) begin
      if (sc_clr)       alu_f[0] = 1'b0;
      else if (sc_en)   alu_f[0] = sc_o;
      if (pari_clr)     alu_f[1] = 1'b0;
      else if (pari_en) alu_f[1] = pari;
      if (z_en)         alu_f[2] = (rslt == 8'h00);
    end

    {z_d, p_d, sc_d} = cur;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = '0;

    if (!stall) begin
      {z_d, p_d, sc_d} = alu_f;
      ovf_d = ovf_q & ~err_clr;
      unf_d = unf_q & ~err_clr;
      if (pop && empty) begin
        unf_d = 1'b1;
      end else if (pop) begin
        // Pop (alone or as a swap with push) overrides the ALU update.
        {z_d, p_d, sc_d} = stk_q[top_idx];
        if (push) begin
          we    = 1'b1;
          waddr = top_idx;
        end else begin
          depth_d = depth_q - 1'b1;
        end
      end else if (push && full) begin
        ovf_d = 1'b1;
      end else if (push) begin
        we      = 1'b1;
        waddr   = AW'(depth_q);
        depth_d = depth_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_q    <= 1'b0;
      p_q     <= 1'b0;
      z_q     <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sc_q    <= sc_d;
      p_q     <= p_d;
      z_q     <= z_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset; entries beyond depth are never read.
  always_ff @(posedge clk) begin
    if (we) stk_q[waddr] <= cur;
  end

  always_comb begin
    case (cond)
      2'b00:   take = 1'b1;
      2'b01:   take = sc_q;
      2'b10:   take = z_q;
      default: take = p_q;
    endcase
  end

  assign sc_i      = sc_q;
  assign pari_in   = p_q;
  assign zero      = z_q;
  assign stk_depth = depth_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;
endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: queue-based flag/stack model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_flag_unit;
  logic clk = 1'b0, reset = 1'b0;
  logic alu_valid, stall, sc_o, sc_en, sc_clr, pari, pari_en, pari_clr;
  logic [7:0] rslt;
  logic z_en, push, pop, err_clr;
  logic [1:0] cond;
  logic sc_i, pari_in, zero, take, stk_full, stk_empty, stk_ovf, stk_unf;
  logic [2:0] stk_depth;

  int chk_cnt = 0, pass_cnt = 0;
  int cond_cnt = 0;

  flag_unit #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .stall(stall),
    .sc_o(sc_o), .sc_en(sc_en), .sc_clr(sc_clr), .pari(pari),
    .pari_en(pari_en), .pari_clr(pari_clr), .rslt(rslt), .z_en(z_en),
    .push(push), .pop(pop), .err_clr(err_clr), .cond(cond),
    .sc_i(sc_i), .pari_in(pari_in), .zero(zero), .take(take),
    .stk_depth(stk_depth), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: flags as {Z,P,SC}, stack as a queue whose back is the top.
  bit [2:0] m_f = 3'b000;
  bit [2:0] m_stk[$];
  bit m_ovf = 1'b0, m_unf = 1'b0;

  always @(posedge clk or posedge reset) begin
    bit [2:0] upd, tmp;
    bit new_ovf, new_unf;
    if (reset) begin
      m_f = 3'b000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!stall) begin
      upd = m_f;
      if (alu_valid) begin
        upd[0] = sc_clr ? 1'b0 : (sc_en ? sc_o : m_f[0]);
        upd[1] = pari_clr ? 1'b0 : (pari_en ? pari : m_f[1]);
        upd[2] = z_en ? (rslt == 8'h00) : m_f[2];
      end
      new_ovf = 1'b0; new_unf = 1'b0;
      if (pop && m_stk.size() == 0) begin
        new_unf = 1'b1; m_f = upd;
      end else if (push && pop) begin
        tmp = m_stk[m_stk.size()-1];
        m_stk[m_stk.size()-1] = m_f;
        m_f = tmp;
      end else if (pop) begin
        m_f = m_stk.pop_back();
      end else if (push && m_stk.size() == 4) begin
        new_ovf = 1'b1; m_f = upd;
      end else if (push) begin
        m_stk.push_back(m_f); m_f = upd;
      end else begin
        m_f = upd;
      end
      m_ovf = new_ovf || (m_ovf && !err_clr);
      m_unf = new_unf || (m_unf && !err_clr);
    end
  end

  always @(negedge clk) begin
    bit m_take;
    int n;
    n = m_stk.size();
    m_take = (cond == 2'd0) ? 1'b1 : (cond == 2'd1) ? m_f[0] : (cond == 2'd2) ? m_f[2] : m_f[1];
    check("cycle",
          {21'd0, sc_i, pari_in, zero, take, stk_depth, stk_full, stk_empty, stk_ovf, stk_unf},
          {21'd0, m_f[0], m_f[1], m_f[2], m_take, 3'(n), n == 4, n == 0, m_ovf, m_unf});
  end

  task automatic idle();
    alu_valid = 0; stall = 0; sc_o = 0; sc_en = 0; sc_clr = 0;
    pari = 0; pari_en = 0; pari_clr = 1; rslt = 8'hff; z_en = 0;
    push = 0; pop = 0; err_clr = 0;
    cond = 2'(cond_cnt); cond_cnt++;
  endtask

  task automatic tick();
    @(posedge clk); #1; idle();
  endtask

  task automatic set_alu(input logic [2:0] f);
    alu_valid = 1; sc_en = 1; sc_o = f[0]; pari_en = 1; pari = f[1];
    pari_clr = 0; z_en = 1; rslt = f[2] ? 8'h00 : 8'h5a;
  endtask

  bit [2:0] drain_exp [4] = '{3'b011, 3'b100, 3'b010, 3'b001};

  initial begin
    idle(); cond = 2'b00;
    #1 reset = 1;
    #2;
    check("rst_flags", {zero, pari_in, sc_i, take}, 4'b0001);
    check("rst_stk", {stk_depth, stk_full, stk_empty, stk_ovf, stk_unf}, {3'd0, 1'b0, 1'b1, 2'b00});
    @(negedge clk); reset = 0;

    alu_valid = 1; sc_en = 1; sc_o = 1; pari_clr = 1; z_en = 1; rslt = 8'h00;
    tick();
    check("gate_on", {zero, pari_in, sc_i}, 3'b101);
    alu_valid = 0; sc_clr = 1;
    tick();
    check("gate_off", {zero, pari_in, sc_i}, 3'b101);

    alu_valid = 1; sc_en = 1; sc_clr = 1; sc_o = 1;
    tick();
    check("sc_clr_prio", sc_i, 0);
    alu_valid = 1; pari_en = 1; pari = 1; pari_clr = 0;
    tick();
    check("p_load", pari_in, 1);
    cond = 2'b11; #1;
    check("take_p", take, 1);

    set_alu(3'b001); tick();
    push = 1; set_alu(3'b010); tick();
    push = 1; set_alu(3'b100); tick();
    push = 1; set_alu(3'b011); tick();
    push = 1; tick();
    check("fill_full", {stk_depth, stk_full, stk_ovf}, {3'd4, 1'b1, 1'b0});
    push = 1; tick();
    check("ovf", {stk_depth, stk_ovf}, {3'd4, 1'b1});
    for (int i = 0; i < 4; i++) begin
      pop = 1; tick();
      check("drain", {zero, pari_in, sc_i}, drain_exp[i]);
    end
    pop = 1; tick();
    check("unf", {stk_unf, stk_empty, zero, pari_in, sc_i}, {2'b11, 3'b001});

    set_alu(3'b010); tick();
    push = 1; set_alu(3'b101); tick();
    push = 1; pop = 1; alu_valid = 1; sc_clr = 1; tick();
    check("swap_flags", {zero, pari_in, sc_i, stk_depth}, {3'b010, 3'd1});
    pop = 1; tick();
    check("swap_top", {zero, pari_in, sc_i, stk_depth}, {3'b101, 3'd0});
    push = 1; alu_valid = 1; sc_en = 1; sc_o = 0; tick();
    check("push_live", {zero, pari_in, sc_i}, 3'b100);
    pop = 1; tick();
    check("push_saved", {zero, pari_in, sc_i}, 3'b101);

    err_clr = 1; tick();
    check("err_clr", {stk_ovf, stk_unf}, 2'b00);
    repeat (5) begin push = 1; tick(); end
    check("ovf2", {stk_ovf, stk_depth}, {1'b1, 3'd4});
    stall = 1; err_clr = 1; pop = 1; set_alu(3'b000); tick();
    check("stall", {stk_ovf, stk_depth, zero, pari_in, sc_i}, {1'b1, 3'd4, 3'b101});
    err_clr = 1; push = 1; tick();
    check("ovf_wins", stk_ovf, 1);
    err_clr = 1; tick();
    check("ovf_cleared", stk_ovf, 0);

    pop = 1; tick();
    pop = 1; tick();
    alu_valid = 1; sc_en = 1; sc_o = 1; tick();
    check("pre_rst", {stk_depth, sc_i}, {3'd2, 1'b1});
    #2 reset = 1;
    #1;
    check("rst_mid_flags", {zero, pari_in, sc_i}, 3'b000);
    check("rst_mid_stk", {stk_depth, stk_full, stk_empty, stk_ovf, stk_unf}, {3'd0, 1'b0, 1'b1, 2'b00});
    @(negedge clk); reset = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Holds the processor's status flags: shift/carry (SC), parity (P) and zero (Z).
- Consumes the ALU's flag outputs and update/clear strobes, and feeds the registered SC and P back to the ALU's sc_i and pari_in inputs.
- Provides a small flag stack for call/return save/restore and a branch-condition evaluator for the control unit.
- Sits between the ALU and the control/PC-next logic.

Parameters:
- DEPTH, 4: flag stack entries; must be a power of two, 2..16.
- DW, 3: stack entry width, {Z, P, SC}; fixed, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  qualifies all ALU strobes this cycle
- stall  in  1  freezes all state when high
- sc_o  in  1  ALU shift/carry out
- sc_en  in  1  ALU: load SC from sc_o
- sc_clr  in  1  ALU: clear SC
- pari  in  1  ALU parity result
- pari_en  in  1  ALU: load P from pari
- pari_clr  in  1  ALU: clear P
- rslt  in  8  ALU result, used for the zero flag
- z_en  in  1  load Z from (rslt == 0)
- push  in  1  save current flags to stack
- pop  in  1  restore flags from stack
- err_clr  in  1  clear sticky stack errors
- cond  in  2  branch condition select
- sc_i  out  1  registered SC, to ALU
- pari_in  out  1  registered P, to ALU
- zero  out  1  registered Z
- take  out  1  branch condition true (combinational)
- stk_depth  out  $clog2(DEPTH)+1  entries in use
- stk_full  out  1  stk_depth == DEPTH
- stk_empty  out  1  stk_depth == 0
- stk_ovf  out  1  sticky: push while full
- stk_unf  out  1  sticky: pop while empty

Behaviour:
- Reset (async, immediate): SC=0, P=0, Z=0, stk_depth=0, stk_ovf=0, stk_unf=0, stk_empty=1, stk_full=0. Stack contents are don't-care.
- All state updates occur on the rising clk edge. Flags are visible on outputs one cycle after the update strobe.
- stall=1: no register changes, regardless of any other input. err_clr is also ignored.
- ALU updates apply only when alu_valid=1. When alu_valid=0, all ALU strobes are ignored. The ALU drives pari_clr=1 by default, so P must not clear without alu_valid.
- SC update: sc_clr=1 → SC=0; else sc_en=1 → SC=sc_o; else hold. Clear has priority.
- P update: pari_clr=1 → P=0; else pari_en=1 → P=pari; else hold. Clear has priority.
- Z update: z_en=1 (with alu_valid) → Z = (rslt == 8'h00); else hold.
- Push only (not full): stack[depth] = current registered {Z,P,SC}, i.e. pre-update values; depth+1. ALU updates in the same cycle still apply to the flags.
- Pop only (not empty): {Z,P,SC} = stack[depth-1]; depth-1. Pop overrides any ALU update in the same cycle.
- Push and pop together: depth unchanged, top entry and flags swap. Flags take the old top, the top takes the current flags, and ALU updates are dropped. If empty: treated as pop-on-empty (stk_unf=1, no change). If full and non-empty: the swap proceeds normally.
- Push while full: no stack or depth change, stk_ovf=1. ALU updates still apply.
- Pop while empty: flags and depth unchanged, stk_unf=1. ALU updates still apply.
- Sticky errors: cleared only by reset, or by err_clr=1 when not stalled. A new error in the same cycle as err_clr wins, so the error flag stays 1.
- take: cond=00 → 1; 01 → SC; 10 → Z; 11 → P. Uses the registered flags only, with no bypass of the current cycle's update.

Test Plan:
- Reset mid-operation: with depth=2 and SC=1, assert reset between clock edges → all outputs go to reset values immediately, before the next clk edge.
- ALU gating: alu_valid=1, sc_en=1, sc_o=1, pari_clr=1, z_en=1, rslt=8'h00 → next cycle sc_i=1, pari_in=0, zero=1. Then alu_valid=0, sc_clr=1 → SC stays 1.
- Clear priority: alu_valid=1, sc_en=1, sc_clr=1, sc_o=1 → SC=0. Then pari_en=1, pari=1, pari_clr=0 → P=1, and cond=11 gives take=1 the following cycle.
- Stack fill/drain: with DEPTH=4, push flags 3'b001, 3'b010, 3'b100, 3'b011 → stk_full=1. A fifth push sets stk_ovf=1 with depth staying 4. Four pops restore 011, 100, 010, 001 in order; a fifth pop sets stk_unf=1 and flags hold 001.
- Simultaneous events: flags=3'b101 with top=3'b010, push+pop → flags=010, top=101, depth unchanged. Push with sc_en=1, sc_o=0 → stacked value keeps SC=1 and the live SC becomes 0.
- Stall and err_clr: with stk_ovf=1 and stall=1, assert err_clr plus a pop → nothing changes. Release stall with err_clr=1 and a push while full → stk_ovf stays 1.
